// File: rtl/lut_config_loader_if.sv
// lut_config_loader_if: configuration byte stream in, LUT truth-table write port out
interface lut_config_loader_if #(parameter int ADDR_W = 4);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [63:0] cfg_data;
  logic cfg_we;
  modport master(output in_data, in_valid, input in_ready, cfg_addr, cfg_data, cfg_we);
  modport slave(input in_data, in_valid, output in_ready, cfg_addr, cfg_data, cfg_we);
endinterface

// File: rtl/lut_config_loader.sv
// lut_config_loader: parses framed config bytes, verifies each record and writes LUT truth tables
module lut_config_loader #(
  parameter int NUM_LUTS = 16,
  parameter int ADDR_W = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  lut_config_loader_if.slave bus,
  output logic busy,
  output logic done,
  output logic error,
  output logic [1:0] error_code
);
  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CHECK, WRITE} state_t;
  localparam logic [8:0] LUTS = 9'(NUM_LUTS);
  state_t state;
  logic [7:0] idx, rem, xsum;
  logic [2:0] cnt;
  logic [63:0] word;
  logic xfer;
  assign bus.in_ready = state != WRITE;
  assign busy = state != IDLE;
  assign xfer = bus.in_valid & bus.in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      rem <= '0;
      xsum <= '0;
      cnt <= '0;
      word <= '0;
      bus.cfg_addr <= '0;
      bus.cfg_data <= '0;
      bus.cfg_we <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      error_code <= 2'b00;
    end else begin
      bus.cfg_we <= 1'b0;
      case (state)
        IDLE: if (xfer && bus.in_data == SYNC_BYTE) begin
          done <= 1'b0;
          error <= 1'b0;
          error_code <= 2'b00;
          state <= ADDR;
        end
        ADDR: if (xfer) begin
          idx <= bus.in_data;
          state <= COUNT;
        end
        COUNT: if (xfer) begin
          // 9-bit range check so start+count cannot wrap past 255
          if (bus.in_data == 8'd0 || 9'(idx) >= LUTS || 9'(idx) + 9'(bus.in_data) > LUTS) begin
            error <= 1'b1;
            error_code <= 2'b01;
            state <= IDLE;
          end else begin
            rem <= bus.in_data;
            cnt <= '0;
            xsum <= '0;
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          word[{cnt, 3'b000} +: 8] <= bus.in_data;
          xsum <= xsum ^ bus.in_data;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) state <= CHECK;
        end
        CHECK: if (xfer) begin
          // strobe is launched here so it is high during the WRITE cycle itself
          if (bus.in_data == xsum) begin
            bus.cfg_we <= 1'b1;
            bus.cfg_addr <= ADDR_W'(idx);
            bus.cfg_data <= word;
            state <= WRITE;
          end else begin
            error <= 1'b1;
            error_code <= 2'b10;
            state <= IDLE;
          end
        end
        WRITE: begin
          idx <= idx + 8'd1;
          rem <= rem - 8'd1;
          cnt <= '0;
          xsum <= '0;
          if (rem == 8'd1) begin
            done <= 1'b1;
            state <= IDLE;
          end else state <= DATA;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/lut_config_loader.md
Name: lut_config_loader

Overview:
- Byte-stream configuration controller for an array of NUM_LUTS 6-input LUTs. Each LUT holds a 64-bit truth table.
- Accepts framed configuration bytes over a valid/ready interface and assembles them into 64-bit truth tables.
- Checks each record, then issues one write per LUT into the fabric's truth-table storage.
- Sits between the bitstream port and the LUT configuration registers; sequences all truth-table updates.

Parameters:
NUM_LUTS, 16, number of LUTs addressable (1..256)
ADDR_W, 4, width of cfg_addr; must satisfy 2**ADDR_W >= NUM_LUTS
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  configuration byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte; a byte transfers when in_valid & in_ready
cfg_addr  output  ADDR_W  LUT index being written
cfg_data  output  64  truth table; bit i is the output for selector value i
cfg_we  output  1  one-cycle write strobe for cfg_addr/cfg_data
busy  output  1  frame in progress (state != IDLE)
done  output  1  sticky: last frame completed with no error
error  output  1  sticky: last frame aborted
error_code  output  2  00 none, 01 range/count error, 10 checksum error

Behaviour:
- Reset (async assert, sync release): state IDLE; cfg_addr=0, cfg_data=0, cfg_we=0, busy=0, done=0, error=0, error_code=00. in_ready=1 (IDLE accepts).
- Frame format: SYNC_BYTE, start index S, count C, then C records. Each record is 8 data bytes (first byte -> cfg_data[7:0], last byte -> [63:56]) followed by 1 check byte equal to the XOR of the 8 data bytes.
- IDLE: accepted bytes other than SYNC_BYTE are dropped silently. On SYNC_BYTE: clear done, error and error_code; go to ADDR.
- ADDR: latch S; go to COUNT.
- COUNT: latch C.
  - If C==0, S>=NUM_LUTS or S+C>NUM_LUTS (9-bit compare, no wrap): error=1, error_code=01, go to IDLE.
  - Otherwise set the byte counter to 0, clear the running XOR and go to DATA.
- DATA: shift each byte into the 64-bit assembly register at byte position = counter, and update the running XOR. After the 8th byte, go to CHECK.
- CHECK:
  - Check byte matches the running XOR: go to WRITE.
  - Mismatch: error=1, error_code=10, no write, go to IDLE. Earlier records in the frame stay written.
- WRITE: exactly one cycle.
  - cfg_we=1, cfg_addr=current index, cfg_data=assembled word. in_ready=0.
  - Then index+1 and remaining−1. If remaining was 1: done=1, go to IDLE. Else go to DATA with counter and XOR cleared.
- in_ready=1 in IDLE, ADDR, COUNT, DATA, CHECK; 0 in WRITE. No state advances without a transfer; in_valid low stalls indefinitely.
- cfg_addr and cfg_data are registered and hold their last written values between writes. cfg_we is high for only one cycle per record.
- Latency: the check byte is accepted in cycle N; cfg_we is high in cycle N+1; the next byte can be accepted in cycle N+2.
- SYNC_BYTE appearing inside a frame is treated as data; there is no resynchronisation mid-frame.
- rst_n asserted mid-frame: immediate return to reset values. A partially assembled record is discarded and no write is issued.
- busy=1 in every state except IDLE.

Test Plan:
- Reset, then stream A5,03,01 + bytes 01..08 + check 08 -> one cfg_we pulse with cfg_addr=3, cfg_data=64'h0807060504030201; done=1; busy falls the cycle after the write.
- Frame A5,0E,02 + two valid records -> writes to addr 14 then 15, exactly two cfg_we pulses. Then A5,0F,02 -> error=1, error_code=01, no write; next A5 clears error.
- Frame A5,00,02: record 0 valid, record 1 with check byte XOR-ed by 0x01 -> one write (addr 0), then error_code=10, state IDLE, done=0.
- Garbage bytes 00,FF,5A before A5, plus random in_valid gaps and a WRITE-cycle stall -> the same write as a clean stream. in_ready=0 exactly in the WRITE cycle.
- Assert rst_n low after the 5th data byte of a record -> all outputs return to reset values, no cfg_we. A subsequent full frame completes normally.
- Count 0 (A5,00,00) -> error_code=01 and no write; a 16-LUT full load (A5,00,10) -> 16 writes with addr 0..15 in order and done=1.
